// File: rtl/arduino_cmd_rx_if.sv
// Host-side byte bus, PWM commit pulse and the register outputs that feed the PWM stage.
// The master modport is the host/PWM side; the slave modport is the command receiver.
interface arduino_cmd_rx_if;
    logic [7:0] data_in;
    logic       wr_strobe;
    logic       update_en;
    logic [7:0] duty;
    logic [7:0] max_value;
    logic       pwm_enable;
    logic       ack;
    logic       err;

    modport master (
        output data_in, wr_strobe, update_en,
        input  duty, max_value, pwm_enable, ack, err
    );

    modport slave (
        input  data_in, wr_strobe, update_en,
        output duty, max_value, pwm_enable, ack, err
    );
endinterface

// File: rtl/arduino_cmd_rx.sv
// Receives two-byte (header, data) write frames from the Arduino parallel bus and
// drives the PWM duty/max_value through shadow registers committed at period end.
module arduino_cmd_rx #(
    parameter int TIMEOUT = 1000000,
    parameter int TO_W    = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    arduino_cmd_rx_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ADDR = 1'b1;

    logic            s1, s2, s3;
    logic            byte_evt;
    logic [0:0]      state;
    logic [1:0]      addr;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      stg_duty, stg_max, ctrl;
    logic [7:0]      duty_q, max_q;
    logic            ack_q, err_q;
    logic            unused_ctrl;

    assign byte_evt = s2 & ~s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.wr_strobe;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Non-blocking reads here see the staged value from before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= 8'h00;
            max_q  <= 8'hFF;
        end else if (bus.update_en) begin
            duty_q <= stg_duty;
            max_q  <= stg_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= 2'd0;
            to_cnt   <= '0;
            stg_duty <= 8'h00;
            stg_max  <= 8'hFF;
            ctrl     <= 8'h00;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_evt) begin
                        if (bus.data_in[7]) begin
                            addr   <= bus.data_in[1:0];
                            to_cnt <= '0;
                            state  <= ADDR;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    // A data byte on the expiry cycle wins over the timeout.
                    if (byte_evt) begin
                        case (addr)
                            2'd0:    stg_duty <= bus.data_in;
                            2'd1:    stg_max  <= bus.data_in;
                            2'd2:    ctrl     <= bus.data_in;
                            default: err_q    <= 1'b0;
                        endcase
                        ack_q <= ~ack_q;
                        state <= IDLE;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign unused_ctrl    = ^ctrl[7:1];
    assign bus.duty       = duty_q;
    assign bus.max_value  = max_q;
    assign bus.pwm_enable = ctrl[0];
    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Directed bench for arduino_cmd_rx: frames, shadow commits, collisions, protocol errors
// and asynchronous reset, each scenario checked against hand-computed values.
module tb_arduino_cmd_rx;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    arduino_cmd_rx_if bus();

    arduino_cmd_rx #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Strobe rises at a negedge; staging edge is the third posedge after that.
    task automatic send_byte(input logic [7:0] b, input bit upd_on_stage);
        @(negedge clk) bus.data_in = b;
        @(negedge clk);
        @(negedge clk) bus.wr_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk) if (upd_on_stage) bus.update_en = 1'b1;
        @(negedge clk) bus.update_en = 1'b0;
        @(negedge clk) bus.wr_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_update();
        @(negedge clk) bus.update_en = 1'b1;
        @(negedge clk) bus.update_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.data_in = 8'h00;
        bus.wr_strobe = 1'b0;
        bus.update_en = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.duty !== 8'h00) begin errors++; $display("[TB] FAIL reset_duty: got %h required 00", bus.duty); end
        checks++; if (bus.max_value !== 8'hFF) begin errors++; $display("[TB] FAIL reset_max: got %h required FF", bus.max_value); end
        checks++; if (bus.pwm_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_pwm_enable: got %b required 0", bus.pwm_enable); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b required 0", bus.ack); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b required 0", bus.err); end
    endtask

    task automatic test_duty_shadow();
        send_byte(8'h80, 1'b0);
        send_byte(8'h40, 1'b0);
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL shadow_ack: got %b required 1", bus.ack); end
        checks++; if (bus.duty !== 8'h00) begin errors++; $display("[TB] FAIL shadow_hold: got %h required 00", bus.duty); end
        pulse_update();
        checks++; if (bus.duty !== 8'h40) begin errors++; $display("[TB] FAIL shadow_commit: got %h required 40", bus.duty); end
        checks++; if (bus.max_value !== 8'hFF) begin errors++; $display("[TB] FAIL shadow_max_kept: got %h required FF", bus.max_value); end
    endtask

    task automatic test_enable();
        send_byte(8'h82, 1'b0);
        @(negedge clk) bus.data_in = 8'h01;
        @(negedge clk);
        @(negedge clk) bus.wr_strobe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.pwm_enable !== 1'b0) begin errors++; $display("[TB] FAIL enable_early: got %b required 0", bus.pwm_enable); end
        @(negedge clk);
        checks++; if (bus.pwm_enable !== 1'b1) begin errors++; $display("[TB] FAIL enable_edge: got %b required 1", bus.pwm_enable); end
        @(negedge clk) bus.wr_strobe = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL enable_ack: got %b required 0", bus.ack); end
        send_byte(8'h81, 1'b0);
        send_byte(8'h7F, 1'b0);
        pulse_update();
        checks++; if (bus.max_value !== 8'h7F) begin errors++; $display("[TB] FAIL max_commit: got %h required 7F", bus.max_value); end
        checks++; if (bus.duty !== 8'h40) begin errors++; $display("[TB] FAIL max_duty_kept: got %h required 40", bus.duty); end
    endtask

    task automatic test_collision();
        send_byte(8'h80, 1'b0);
        send_byte(8'h20, 1'b1);
        checks++; if (bus.duty !== 8'h40) begin errors++; $display("[TB] FAIL collision_old: got %h required 40", bus.duty); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL collision_ack: got %b required 0", bus.ack); end
        pulse_update();
        checks++; if (bus.duty !== 8'h20) begin errors++; $display("[TB] FAIL collision_next: got %h required 20", bus.duty); end
    endtask

    task automatic test_errors();
        send_byte(8'h15, 1'b0);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL lone_byte_err: got %b required 1", bus.err); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL lone_byte_ack: got %b required 0", bus.ack); end
        pulse_update();
        checks++; if (bus.duty !== 8'h20) begin errors++; $display("[TB] FAIL lone_byte_duty: got %h required 20", bus.duty); end
        checks++; if (bus.pwm_enable !== 1'b1) begin errors++; $display("[TB] FAIL lone_byte_pwm: got %b required 1", bus.pwm_enable); end
        send_byte(8'h83, 1'b0);
        send_byte(8'h00, 1'b0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL clear_err: got %b required 0", bus.err); end
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL clear_ack: got %b required 1", bus.ack); end
        // Header edge is about 5.5 cycles back; 16-cycle timeout not yet reached.
        send_byte(8'h80, 1'b0);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early: got %b required 0", bus.err); end
        repeat (12) @(negedge clk);
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err: got %b required 1", bus.err); end
        checks++; if (bus.ack !== 1'b1) begin errors++; $display("[TB] FAIL timeout_ack: got %b required 1", bus.ack); end
        send_byte(8'h80, 1'b0);
        send_byte(8'h11, 1'b0);
        pulse_update();
        checks++; if (bus.duty !== 8'h11) begin errors++; $display("[TB] FAIL after_timeout_duty: got %h required 11", bus.duty); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL after_timeout_ack: got %b required 0", bus.ack); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b required 1", bus.err); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'h80, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        #2;
        checks++; if (bus.duty !== 8'h00) begin errors++; $display("[TB] FAIL midreset_duty: got %h required 00", bus.duty); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("[TB] FAIL midreset_err: got %b required 0", bus.err); end
        checks++; if (bus.pwm_enable !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pwm: got %b required 0", bus.pwm_enable); end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        send_byte(8'h55, 1'b0);
        pulse_update();
        checks++; if (bus.err !== 1'b1) begin errors++; $display("[TB] FAIL midreset_byte_err: got %b required 1", bus.err); end
        checks++; if (bus.duty !== 8'h00) begin errors++; $display("[TB] FAIL midreset_byte_duty: got %h required 00", bus.duty); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("[TB] FAIL midreset_byte_ack: got %b required 0", bus.ack); end
    endtask

    initial begin
        test_reset();
        test_duty_shadow();
        test_enable();
        test_collision();
        test_errors();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
